// File: rtl/drp_adc_responder.sv
// rtl/drp_adc_responder.sv - DRP-compatible stand-in for the ADC hard macro
// 128x16 register file behind a fixed-latency DRP responder, plus a periodic fake conversion engine.
module drp_adc_responder #(
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned EOC_PERIOD  = 26,
  parameter logic [6:0]  SAMPLE_ADDR = 7'h13
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [6:0]  DADDR_IN,
  input  logic        DEN_IN,
  input  logic        DWE_IN,
  input  logic [15:0] DI_IN,
  output logic [15:0] DO_OUT,
  output logic        DRDY_OUT,
  output logic        BUSY_OUT,
  output logic        EOC_OUT,
  output logic [4:0]  CHANNEL_OUT,
  input  logic [11:0] sample_in,
  output logic        proto_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [3:0]  LAT_LOAD   = 4'(LATENCY - 1);
  localparam logic [15:0] TERM       = 16'(EOC_PERIOD - 1);
  localparam logic [15:0] BUSY_START = 16'(EOC_PERIOD - 4);

  state_t      state_q;
  logic [3:0]  lat_q;
  logic [6:0]  addr_q;
  logic        we_q;
  logic [15:0] di_q;
  logic [15:0] do_q;
  logic        drdy_q;
  logic        busy_q;
  logic        eoc_q;
  logic        perr_q;
  logic [4:0]  chan_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        terminal;
  logic [15:0] mem_q [128];

  assign terminal = (cnt_q == TERM);
  assign cnt_d    = terminal ? 16'd0 : cnt_q + 16'd1;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= S_IDLE;
      lat_q   <= 4'd0;
      addr_q  <= 7'd0;
      we_q    <= 1'b0;
      di_q    <= 16'd0;
      do_q    <= 16'd0;
      drdy_q  <= 1'b0;
      busy_q  <= 1'b0;
      eoc_q   <= 1'b0;
      perr_q  <= 1'b0;
      chan_q  <= 5'd0;
      cnt_q   <= 16'd0;
      for (int i = 0; i < 128; i++) mem_q[i] <= 16'd0;
    end else begin
      drdy_q <= 1'b0;
      eoc_q  <= terminal;
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d >= BUSY_START);

      case (state_q)
        S_IDLE: begin
          if (DEN_IN) begin
            addr_q  <= DADDR_IN;
            we_q    <= DWE_IN;
            di_q    <= DI_IN;
            lat_q   <= LAT_LOAD;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A new request while one is outstanding is dropped, but remembered.
          if (DEN_IN) perr_q <= 1'b1;
          if (lat_q == 4'd0) begin
            if (we_q) mem_q[addr_q] <= di_q;
            else      do_q <= mem_q[addr_q];
            drdy_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Placed after the DRP write so the conversion value wins a same-edge collision.
      if (terminal) begin
        mem_q[SAMPLE_ADDR] <= {sample_in, 4'h0};
        chan_q             <= SAMPLE_ADDR[4:0];
      end
    end
  end

  assign DO_OUT      = do_q;
  assign DRDY_OUT    = drdy_q;
  assign BUSY_OUT    = busy_q;
  assign EOC_OUT     = eoc_q;
  assign CHANNEL_OUT = chan_q;
  assign proto_err   = perr_q;

endmodule

// File: tb/tb_drp_adc_responder.sv
// tb/tb_drp_adc_responder.sv - directed scoreboard bench for drp_adc_responder
module tb_drp_adc_responder;

  localparam int         LAT = 4;
  localparam int         PER = 26;
  localparam logic [6:0] SA  = 7'h13;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [6:0]  daddr = 7'd0;
  logic        den_tb = 1'b0;
  logic        dwe = 1'b0;
  logic [15:0] di = 16'd0;
  logic [11:0] sample = 12'd0;
  logic        loop = 1'b0;
  logic        den;
  logic [15:0] dout;
  logic        drdy, busy, eoc, perr;
  logic [4:0]  chan;

  assign den = loop ? eoc : den_tb;

  always #5 clk = ~clk;

  drp_adc_responder #(.LATENCY(LAT), .EOC_PERIOD(PER), .SAMPLE_ADDR(SA)) dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (rst_n),
    .DADDR_IN    (daddr),
    .DEN_IN      (den),
    .DWE_IN      (dwe),
    .DI_IN       (di),
    .DO_OUT      (dout),
    .DRDY_OUT    (drdy),
    .BUSY_OUT    (busy),
    .EOC_OUT     (eoc),
    .CHANNEL_OUT (chan),
    .sample_in   (sample),
    .proto_err   (perr)
  );

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          mcnt = 0;
  logic [15:0] mem_m [128];
  logic [15:0] exp_do = 16'd0;
  logic        eoc_exp = 1'b0;
  logic        busy_exp = 1'b0;
  logic        proto_exp = 1'b0;
  logic [4:0]  chan_exp = 5'd0;
  logic        in_reset = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    if (in_reset) begin
      mcnt = 0; eoc_exp = 1'b0; busy_exp = 1'b0; chan_exp = 5'd0;
      exp_do = 16'd0; proto_exp = 1'b0;
    end else begin
      eoc_exp = (mcnt == PER - 1);
      if (eoc_exp) begin
        mem_m[SA] = {sample, 4'h0};
        chan_exp  = SA[4:0];
      end
      mcnt     = eoc_exp ? 0 : mcnt + 1;
      busy_exp = (mcnt >= PER - 4);
      if (loop && eoc_exp) begin
        e.due  = cyc + 1 + LAT;
        e.data = mem_m[SA];
        exp_do = e.data;
        sb.push_back(e);
      end
    end
    #1;
    check("eoc", eoc, eoc_exp);
    check("busy", busy, busy_exp);
    check("channel", chan, chan_exp);
    check("proto_err", perr, proto_exp);
    if (drdy) begin
      if (sb.size() == 0) check("drdy_spurious", drdy, 1'b0);
      else begin
        e = sb.pop_front();
        check("drdy_cycle", cyc, e.due);
        check("do_out", dout, e.data);
      end
    end else if (sb.size() != 0 && sb[0].due == cyc) begin
      check("drdy_missing", drdy, 1'b1);
      void'(sb.pop_front());
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; in_reset = 1'b1; den_tb = 1'b0; loop = 1'b0;
    for (int i = 0; i < 128; i++) mem_m[i] = 16'd0;
    repeat (n) tick();
    check("rst_do", dout, 16'd0);
    check("rst_drdy", drdy, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_eoc", eoc, 1'b0);
    check("rst_chan", chan, 5'd0);
    check("rst_perr", perr, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; in_reset = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic drp(input logic we, input logic [6:0] a, input logic [15:0] d);
    exp_t e;
    den_tb = 1'b1; dwe = we; daddr = a; di = d;
    e.due = cyc + 1 + LAT;
    if (we) begin
      e.data   = exp_do;
      mem_m[a] = d;
    end else begin
      e.data = mem_m[a];
      exp_do = e.data;
    end
    sb.push_back(e);
    tick();
    den_tb = 1'b0; dwe = 1'b0;
    drain();
  endtask

  initial begin
    int n;
    exp_t e;
    #2;
    do_reset(5);

    // first conversion after reset release
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (eoc) break;
    end
    check("first_eoc_delay", n, PER);
    check("first_eoc_chan", chan, 5'h13);

    drp(1'b1, 7'h40, 16'hBEEF);
    drp(1'b0, 7'h40, 16'h0000);
    drp(1'b0, 7'h41, 16'h0000);
    drp(1'b0, 7'h00, 16'h0000);

    // loopback: EOC drives DEN, reading the sample register
    sample = 12'hABC; daddr = SA; dwe = 1'b0;
    while (eoc_exp) tick();
    loop = 1'b1;
    repeat (3 * PER) tick();
    while (eoc_exp) tick();
    loop = 1'b0;
    drain();
    check("loop_perr", perr, 1'b0);

    // DRP write completing on the terminal-count edge
    sample = 12'h123;
    n = 0;
    while (mcnt != PER - 5 && n < 40) begin
      tick();
      n++;
    end
    check("collision_align", mcnt, PER - 5);
    drp(1'b1, SA, 16'h5555);
    drp(1'b0, SA, 16'h0000);
    check("collision_value", dout, 16'h1230);

    // second DEN while a read is outstanding
    den_tb = 1'b1; dwe = 1'b0; daddr = 7'h40;
    e.due = cyc + 1 + LAT; e.data = mem_m[7'h40]; exp_do = e.data;
    sb.push_back(e);
    tick();
    den_tb = 1'b0;
    tick();
    den_tb = 1'b1; dwe = 1'b1; daddr = 7'h05; di = 16'h1234;
    proto_exp = 1'b1;
    tick();
    den_tb = 1'b0; dwe = 1'b0;
    drain();
    drp(1'b0, 7'h05, 16'h0000);
    check("perr_sticky", perr, 1'b1);

    // reset two cycles into a write
    den_tb = 1'b1; dwe = 1'b1; daddr = 7'h20; di = 16'hCAFE;
    tick();
    den_tb = 1'b0; dwe = 1'b0;
    tick();
    tick();
    do_reset(3);
    repeat (6) tick();
    drp(1'b0, 7'h20, 16'h0000);
    drp(1'b0, 7'h40, 16'h0000);
    check("final_queue", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/drp_adc_responder.md
Name: drp_adc_responder

Overview:
- DRP responder that models the ADC's dynamic-reconfiguration port. It presents the same DADDR/DEN/DWE/DI/DO/DRDY/BUSY/EOC/CHANNEL signalling that the ADC reader logic drives and consumes.
- Contains a 128x16 register file and a periodic conversion engine. The engine writes a digital sample into the status register on each conversion and pulses EOC.
- Sits in place of the hard ADC macro for bring-up and simulation, so 7-seg and LED display logic can be exercised with known sample values.

Parameters:
- LATENCY, 4: cycles from accepted DEN to DRDY pulse; legal range 1..15.
- EOC_PERIOD, 26: cycles per conversion; legal range 8..65535.
- SAMPLE_ADDR, 7'h13: register updated by each conversion (VAUX3 status).

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz, all logic on rising edge.
- CPU_RESETN  in  1  asynchronous active-low reset.
- DADDR_IN  in  7  DRP register address.
- DEN_IN  in  1  DRP enable, one-cycle request strobe.
- DWE_IN  in  1  write enable, sampled with DEN_IN.
- DI_IN  in  16  write data, sampled with DEN_IN.
- DO_OUT  out  16  read data, valid when DRDY_OUT=1.
- DRDY_OUT  out  1  one-cycle completion pulse.
- BUSY_OUT  out  1  conversion in progress.
- EOC_OUT  out  1  one-cycle end-of-conversion pulse.
- CHANNEL_OUT  out  5  channel of last conversion.
- sample_in  in  12  unsigned sample to be converted.
- proto_err  out  1  sticky: DEN received while a transaction was outstanding.

Behaviour:
Reset (CPU_RESETN=0, asynchronous):
- All register-file entries = 16'h0000.
- DO_OUT=0, DRDY_OUT=0, BUSY_OUT=0, EOC_OUT=0, CHANNEL_OUT=0, proto_err=0.
- FSM goes to IDLE; latency counter and conversion counter = 0.
- Reset mid-transaction drops the transaction: no DRDY and no write.

DRP FSM, states IDLE and WAIT:
- IDLE and DEN_IN=1: capture DADDR_IN, DWE_IN and DI_IN; load latency counter with LATENCY-1; go to WAIT.
- LATENCY=1: completion occurs on the next edge after the capture edge.
- WAIT: decrement the latency counter each cycle. When it reaches 0, complete the transaction:
  - write: reg[addr] <= DI; DO_OUT unchanged.
  - read: DO_OUT <= reg[addr].
  - DRDY_OUT=1 for exactly one cycle; return to IDLE.
- DRDY is asserted exactly LATENCY cycles after the DEN-sampling edge.
- DEN_IN=1 in WAIT, including the completion cycle: request ignored, proto_err <= 1. proto_err clears only on reset.
- DEN_IN in the cycle after DRDY (FSM back in IDLE) is accepted normally.
- DO_OUT holds its value between reads.

Conversion engine:
- Free-running counter 0..EOC_PERIOD-1, wraps to 0.
- BUSY_OUT=1 while count >= EOC_PERIOD-4.
- At count = EOC_PERIOD-1 (terminal):
  - reg[SAMPLE_ADDR] <= {sample_in, 4'b0000}, left-justified 16-bit.
  - Next cycle: EOC_OUT=1 for one cycle; CHANNEL_OUT <= SAMPLE_ADDR[4:0], held until the next conversion.
- First EOC occurs EOC_PERIOD cycles after reset release.
- sample_in is sampled only at the terminal count.

Collisions:
- A DRP write to SAMPLE_ADDR completing on the same edge as a conversion update: the conversion value wins.
- A DRP read completing on that edge returns the pre-update value.

Loopback:
- With EOC_OUT wired to DEN_IN and DADDR_IN=SAMPLE_ADDR, the read captures on the EOC cycle.
- The returned data is the sample just written, with DRDY LATENCY cycles after EOC.
- Continuous loopback never sets proto_err, because EOC_PERIOD > LATENCY.

Test Plan:
- Reset: hold CPU_RESETN=0 for 5 cycles, then release.
  - All outputs read 0.
  - First EOC_OUT pulse occurs exactly 26 cycles after release.
  - CHANNEL_OUT=5'h13 after that pulse.
- Write then read:
  - Write DI=16'hBEEF to addr 7'h40: DRDY exactly 4 cycles after DEN, DO_OUT unchanged.
  - Read 7'h40: DRDY after 4 cycles with DO_OUT=16'hBEEF. Other addresses read 16'h0000.
- Conversion:
  - sample_in=12'hABC, loopback DEN=EOC, DADDR=7'h13.
  - Each DRDY returns DO_OUT=16'hABC0, 4 cycles after each EOC; proto_err stays 0.
  - BUSY_OUT high for exactly 4 cycles before each EOC.
- Protocol error:
  - Issue DEN, then a second DEN 2 cycles later with a write to 7'h05 of 16'h1234.
  - Only one DRDY occurs; reg[7'h05] stays 16'h0000; proto_err=1 until reset.
- Collision:
  - Time a write of 16'h5555 to 7'h13 to complete on the terminal-count edge, with sample_in=12'h123.
  - A subsequent read returns 16'h1230.
- Reset mid-transaction:
  - Assert CPU_RESETN=0 two cycles after a write DEN to 7'h20.
  - No DRDY occurs; reg[7'h20] reads 16'h0000 after reset release.
